// File: rtl/processador_pkg.sv
// Shared processor definitions: address width, wait-counter width, PC FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package processador_pkg;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        EXECUTA        = 2'd0,
        ESPERA_ENTRADA = 2'd1,
        ESPERA_SAIDA   = 2'd2,
        PARADO         = 2'd3
    } estado_pc_t;

endpackage

// File: rtl/registrador_pc.sv
// Program counter register with jump/branch load, input/output wait states and permanent halt.
// Latency: pc updates on the rising edge after the request; incrementa is combinational.
// Backpressure: waits hold pc until entrada_valida/saida_ack; halt holds it until reset.
module registrador_pc
    import processador_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_ADDR = 32'd0,
    parameter logic [CNT_W-1:0]  SAT_MAX    = 16'hFFFF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] proximo_pc,
    input  logic              salto,
    input  logic              desvio,
    input  logic [ADDR_W-1:0] endereco_alvo,
    input  logic              halt,
    input  logic              req_entrada,
    input  logic              entrada_valida,
    input  logic [ADDR_W-1:0] dado_externo,
    input  logic              req_saida,
    input  logic              saida_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              incrementa,
    output logic [ADDR_W-1:0] dado_entrada,
    output logic              esperando,
    output logic              parado,
    output logic [CNT_W-1:0]  ciclos_espera
);

    estado_pc_t estado;
    estado_pc_t prox_estado;
    logic       carrega_alvo;
    logic       captura;

    // State register; reset returns to EXECUTA from any state, including PARADO.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= EXECUTA;
        end else begin
            estado <= prox_estado;
        end
    end

    // Next-state logic; in EXECUTA the higher-priority requests win, salto/desvio never change state.
    always_comb begin
        prox_estado = estado;
        case (estado)
            EXECUTA: begin
                if (halt)             prox_estado = PARADO;
                else if (req_entrada) prox_estado = ESPERA_ENTRADA;
                else if (req_saida)   prox_estado = ESPERA_SAIDA;
            end
            ESPERA_ENTRADA: if (entrada_valida) prox_estado = EXECUTA;
            ESPERA_SAIDA:   if (saida_ack)      prox_estado = EXECUTA;
            default:        prox_estado = PARADO;
        endcase
    end

    // Output decode; everything that moves the PC is suppressed while reset is asserted.
    always_comb begin
        incrementa   = 1'b0;
        carrega_alvo = 1'b0;
        captura      = 1'b0;
        case (estado)
            EXECUTA: begin
                if (!(halt || req_entrada || req_saida)) begin
                    if (salto || desvio) carrega_alvo = 1'b1;
                    else                 incrementa   = 1'b1;
                end
            end
            ESPERA_ENTRADA: begin
                incrementa = entrada_valida;
                captura    = entrada_valida;
            end
            ESPERA_SAIDA: incrementa = saida_ack;
            default: ;
        endcase
        if (reset) begin
            incrementa   = 1'b0;
            carrega_alvo = 1'b0;
            captura      = 1'b0;
        end
        esperando = (estado == ESPERA_ENTRADA) || (estado == ESPERA_SAIDA);
        parado    = (estado == PARADO);
    end

    // PC register: the external incrementer result wraps modulo 2^32 on its own.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= RESET_ADDR;
        end else if (incrementa) begin
            pc <= proximo_pc;
        end else if (carrega_alvo) begin
            pc <= endereco_alvo;
        end
    end

    // Capture external data on the cycle the input wait completes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dado_entrada <= '0;
        end else if (captura) begin
            dado_entrada <= dado_externo;
        end
    end

    // Saturating count of every cycle spent in a wait state; only reset clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ciclos_espera <= '0;
        end else if (esperando && (ciclos_espera < SAT_MAX)) begin
            ciclos_espera <= ciclos_espera + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_registrador_pc.sv
// Self-checking bench for registrador_pc: directed scenarios then randomized phases.
// Expected values come from a behavioural model of the PC rules kept in this file.
// External incrementer modelled as proximo_pc = pc + 1.
module tb_registrador_pc;

    localparam logic [31:0] RST_ADDR = 32'd0;
    localparam logic [15:0] SAT      = 16'd20;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] proximo_pc;
    logic        salto, desvio, halt, req_entrada, entrada_valida, req_saida, saida_ack;
    logic [31:0] endereco_alvo, dado_externo;
    logic [31:0] pc, dado_entrada;
    logic        incrementa, esperando, parado;
    logic [15:0] ciclos_espera;

    registrador_pc #(.RESET_ADDR(RST_ADDR), .SAT_MAX(SAT)) dut (
        .clock(clock), .reset(reset), .proximo_pc(proximo_pc),
        .salto(salto), .desvio(desvio), .endereco_alvo(endereco_alvo),
        .halt(halt), .req_entrada(req_entrada), .entrada_valida(entrada_valida),
        .dado_externo(dado_externo), .req_saida(req_saida), .saida_ack(saida_ack),
        .pc(pc), .incrementa(incrementa), .dado_entrada(dado_entrada),
        .esperando(esperando), .parado(parado), .ciclos_espera(ciclos_espera)
    );

    assign proximo_pc = pc + 32'd1;

    always #5 clock = ~clock;

    // Behavioural model
    logic [31:0] m_pc, m_dado;
    int          m_cnt;
    bit          m_win, m_wout, m_stop;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_inc();
        if (reset || m_stop) return 1'b0;
        if (m_win)  return entrada_valida;
        if (m_wout) return saida_ack;
        return !(halt || req_entrada || req_saida || salto || desvio);
    endfunction

    task automatic model_reset();
        m_pc = RST_ADDR; m_dado = 32'd0; m_cnt = 0;
        m_win = 0; m_wout = 0; m_stop = 0;
    endtask

    task automatic model_clock();
        if (m_stop) begin
            // stays stopped until reset
        end else if (m_win || m_wout) begin
            if (m_cnt < int'(SAT)) m_cnt++;
            if (m_win && entrada_valida) begin
                m_pc = m_pc + 32'd1; m_dado = dado_externo; m_win = 0;
            end else if (m_wout && saida_ack) begin
                m_pc = m_pc + 32'd1; m_wout = 0;
            end
        end else if (halt)        m_stop = 1;
        else if (req_entrada)     m_win = 1;
        else if (req_saida)       m_wout = 1;
        else if (salto || desvio) m_pc = endereco_alvo;
        else                      m_pc = m_pc + 32'd1;
    endtask

    task automatic check_outputs();
        check("pc", pc, m_pc);
        check("esperando", esperando, m_win || m_wout);
        check("parado", parado, m_stop);
        check("ciclos_espera", ciclos_espera, m_cnt);
        check("dado_entrada", dado_entrada, m_dado);
    endtask

    task automatic idle();
        salto = 0; desvio = 0; halt = 0; req_entrada = 0; req_saida = 0;
        entrada_valida = 0; saida_ack = 0;
        endereco_alvo = $urandom; dado_externo = $urandom;
    endtask

    // Called shortly after a falling edge with inputs already applied.
    task automatic step();
        #1;
        check("incrementa", incrementa, exp_inc());
        @(posedge clock);
        model_clock();
        #1;
        check_outputs();
        @(negedge clock);
    endtask

    // Asserts reset between clock edges, checks reset values, releases after one edge.
    task automatic do_reset();
        #2;
        idle();
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check("incrementa_in_reset", incrementa, 1'b0);
        @(posedge clock);
        #1;
        check_outputs();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic jump_to(input logic [31:0] a);
        idle(); salto = 1; endereco_alvo = a;
        step();
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        model_reset();
        @(negedge clock);
        do_reset();

        // Sequential advance from reset
        repeat (3) step();
        check("seq_pc3", pc, 32'd3);

        // salto and desvio together, then desvio alone
        idle(); salto = 1; desvio = 1; endereco_alvo = 32'h40;
        step();
        check("salto_pc", pc, 32'h40);
        idle(); desvio = 1; endereco_alvo = 32'h80;
        step();
        check("desvio_pc", pc, 32'h80);

        // Input wait at pc=5 completing on the fourth wait cycle
        jump_to(32'd5);
        req_entrada = 1; salto = 1; endereco_alvo = 32'h99;
        step();
        idle();
        repeat (3) step();
        check("wait_in_pc", pc, 32'd5);
        check("wait_in_esperando", esperando, 1'b1);
        entrada_valida = 1; dado_externo = 32'hCAFE;
        step();
        check("wait_in_exit_pc", pc, 32'd6);
        check("wait_in_dado", dado_entrada, 32'hCAFE);
        check("wait_in_ciclos", ciclos_espera, 16'd4);

        // Output wait with simultaneous salto, reset asserted mid-wait
        jump_to(32'd9);
        req_saida = 1; salto = 1; endereco_alvo = 32'h123;
        step();
        idle(); halt = 1; entrada_valida = 1;
        step();
        idle();
        step();
        check("wait_out_pc", pc, 32'd9);
        do_reset();
        check("rst_mid_wait_pc", pc, RST_ADDR);
        check("rst_mid_wait_ciclos", ciclos_espera, 16'd0);
        check("rst_mid_wait_esperando", esperando, 1'b0);

        // Halt beats req_entrada; nothing leaves PARADO but reset
        jump_to(32'd7);
        halt = 1; req_entrada = 1;
        step();
        repeat (10) begin
            idle();
            entrada_valida = 1; saida_ack = 1;
            req_entrada = 1'($urandom); salto = 1'($urandom); halt = 1'($urandom);
            step();
        end
        check("halt_pc", pc, 32'd7);
        check("halt_parado", parado, 1'b1);
        do_reset();
        check("halt_cleared", parado, 1'b0);

        // 32-bit wrap through the external incrementer
        jump_to(32'hFFFFFFFF);
        step();
        check("wrap_pc", pc, 32'd0);

        // Wait counter saturates at SAT_MAX
        req_saida = 1;
        step();
        idle();
        repeat (25) step();
        check("sat_ciclos", ciclos_espera, SAT);
        saida_ack = 1;
        step();
        idle();
        step();

        // Randomized phases
        repeat (6) begin
            do_reset();
            repeat (200) begin
                halt           = ($urandom_range(0, 99) == 0);
                req_entrada    = ($urandom_range(0, 15) == 0);
                req_saida      = ($urandom_range(0, 15) == 0);
                salto          = ($urandom_range(0, 7) == 0);
                desvio         = ($urandom_range(0, 7) == 0);
                entrada_valida = ($urandom_range(0, 2) == 0);
                saida_ack      = ($urandom_range(0, 2) == 0);
                case ($urandom_range(0, 3))
                    0:       endereco_alvo = 32'hFFFFFFFE;
                    1:       endereco_alvo = 32'hFFFFFFFF;
                    default: endereco_alvo = $urandom;
                endcase
                dado_externo = $urandom;
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
